// File: rtl/mips_lite_pkg.sv
// Shared definitions for the multicycle MIPS-lite control path.
package mips_lite_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NORI  = 6'b001100;

  // aluop pair as consumed by alucont
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_NORI  = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_RTEX   = 4'd7,
    ST_RTWB   = 4'd8,
    ST_BEQEX  = 4'd9,
    ST_JEX    = 4'd10,
    ST_NORIEX = 4'd11,
    ST_NORIWB = 4'd12
  } state_t;

  // Moore part of the control word; mem_ready/op qualified terms live in the top
  typedef struct packed {
    logic     pcwrite;
    logic     pcwritecond;
    logic     iord;
    logic     memread;
    logic     memwrite;
    logic     memtoreg;
    logic     regdst;
    logic     regwrite;
    logic     alusrca;
    alusrcb_t alusrcb;
    pcsrc_t   pcsource;
    aluop_t   aluop;
    logic     instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_NORI);
  endfunction

  // Per-state Moore decode; anything not listed stays 0
  function automatic ctrl_t decode_state(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALU_ADD;
      end
      ST_DECODE: begin
        c.alusrcb = SRCB_IMM_SH2;
        c.aluop   = ALU_ADD;
      end
      ST_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_ADD;
      end
      ST_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      ST_MEMWB: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      ST_RTEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluop   = ALU_FUNCT;
      end
      ST_RTWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_BEQEX: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_RT;
        c.aluop       = ALU_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
        c.instr_done  = 1'b1;
      end
      ST_JEX: begin
        c.pcwrite    = 1'b1;
        c.pcsource   = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      ST_NORIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALU_NORI;
      end
      ST_NORIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-path bundle between the main FSM and the datapath.
interface mc_control_if;
  import mips_lite_pkg::*;

  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic       instr_done;
  logic       illegal;

  // controller side
  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, instr_done, illegal
  );

  // datapath side
  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, instr_done, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Main control FSM for multicycle MIPS-lite.
//
//  state  | meaning
//  IDLE   | post-reset, all outputs 0
//  FETCH  | read instruction at PC, PC+4; waits on mem_ready
//  DECODE | register read, branch target calc, opcode dispatch
//  MEMADR | effective address for LW/SW
//  MEMRD  | data read at ALUOut; waits on mem_ready
//  MEMWB  | write MDR to rt, retire LW
//  MEMWR  | data write at ALUOut; waits on mem_ready, retires SW
//  RTEX   | R-type ALU op
//  RTWB   | write ALUOut to rd, retire R-type
//  BEQEX  | compare and conditional PC load, retire BEQ
//  JEX    | PC load from jump target, retire J
//  NORIEX | nor-immediate ALU op
//  NORIWB | write ALUOut to rt, retire NORI
module mc_control
  import mips_lite_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  mc_control_if.master bus
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   fetch_go;
  logic   wr_done;
  logic   bad_op;

  // Next-state selection; op is only looked at in DECODE and MEMADR
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:   nxt = ST_FETCH;
      ST_FETCH:  nxt = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = ST_MEMADR;
          OP_RTYPE:     nxt = ST_RTEX;
          OP_BEQ:       nxt = ST_BEQEX;
          OP_J:         nxt = ST_JEX;
          OP_NORI:      nxt = ST_NORIEX;
          default:      nxt = ST_FETCH;
        endcase
      end
      // op is held stable past DECODE; a non-memory op here is only defensive
      ST_MEMADR: begin
        if (bus.op == OP_LW)      nxt = ST_MEMRD;
        else if (bus.op == OP_SW) nxt = ST_MEMWR;
        else                      nxt = ST_FETCH;
      end
      ST_MEMRD:  nxt = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  nxt = ST_FETCH;
      ST_MEMWR:  nxt = bus.mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTEX:   nxt = ST_RTWB;
      ST_RTWB:   nxt = ST_FETCH;
      ST_BEQEX:  nxt = ST_FETCH;
      ST_JEX:    nxt = ST_FETCH;
      ST_NORIEX: nxt = ST_NORIWB;
      ST_NORIWB: nxt = ST_FETCH;
      default:   nxt = ST_IDLE;
    endcase
  end

  // State register plus Moore outputs registered from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= decode_state(nxt);
    end
  end

  // Same-cycle qualifiers: memory handshake completion and illegal-opcode detect
  always_comb begin
    fetch_go = (state == ST_FETCH) && bus.mem_ready;
    wr_done  = (state == ST_MEMWR) && bus.mem_ready;
    bad_op   = (state == ST_DECODE) && !op_legal(bus.op);
  end

  assign bus.pcwrite     = ctrl_q.pcwrite | fetch_go;
  assign bus.pcwritecond = ctrl_q.pcwritecond;
  assign bus.iord        = ctrl_q.iord;
  assign bus.memread     = ctrl_q.memread;
  assign bus.memwrite    = ctrl_q.memwrite;
  assign bus.irwrite     = fetch_go;
  assign bus.memtoreg    = ctrl_q.memtoreg;
  assign bus.regdst      = ctrl_q.regdst;
  assign bus.regwrite    = ctrl_q.regwrite;
  assign bus.alusrca     = ctrl_q.alusrca;
  assign bus.alusrcb     = ctrl_q.alusrcb;
  assign bus.pcsource    = ctrl_q.pcsource;
  assign bus.aluop1      = ctrl_q.aluop[1];
  assign bus.aluop0      = ctrl_q.aluop[0];
  assign bus.instr_done  = ctrl_q.instr_done | wr_done | bad_op;
  assign bus.illegal     = bad_op;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes the expected control word per cycle.
module tb_mc_control;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] NORI = 6'b001100;
  localparam logic [5:0] BAD  = 6'b111111;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] exp_q[$];
  string       name_q[$];

  function automatic logic [17:0] observed();
    return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
            bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0,
            bus.instr_done, bus.illegal};
  endfunction

  // Hand-written table of expected control words per state
  function automatic logic [17:0] exp_vec(input string st, input bit rdy);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, done, ill;
    logic [1:0] srcb, pcs, aop;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, done, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      "IDLE":       ;
      "FETCH":      begin pw = rdy; irw = rdy; mr = 1'b1; srcb = 2'b01; end
      "DECODE":     srcb = 2'b11;
      "DECODE_BAD": begin srcb = 2'b11; done = 1'b1; ill = 1'b1; end
      "MEMADR":     begin asa = 1'b1; srcb = 2'b10; end
      "MEMRD":      begin mr = 1'b1; iord = 1'b1; end
      "MEMWB":      begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      "MEMWR":      begin mw = 1'b1; iord = 1'b1; done = rdy; end
      "RTEX":       begin asa = 1'b1; aop = 2'b10; end
      "RTWB":       begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
      "BEQEX":      begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; done = 1'b1; end
      "JEX":        begin pw = 1'b1; pcs = 2'b10; done = 1'b1; end
      "NORIEX":     begin asa = 1'b1; srcb = 2'b10; aop = 2'b11; end
      "NORIWB":     begin rw = 1'b1; done = 1'b1; end
      default:      return 18'h3ffff;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, srcb, pcs, aop, done, ill};
  endfunction

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge and queue the expected word
  task automatic cyc(input logic [5:0] op_v, input bit rdy, input string st, input string tag);
    @(posedge clk);
    #1;
    bus.op        = op_v;
    bus.mem_ready = rdy;
    exp_q.push_back(exp_vec(st, rdy));
    name_q.push_back({tag, ":", st});
  endtask

  // Asynchronous reset mid-cycle from a known state, then release into IDLE
  task automatic do_reset(input logic [5:0] op_v, input string pre_st, input bit rdy, input string tag);
    @(posedge clk);
    #1;
    bus.op        = op_v;
    bus.mem_ready = rdy;
    #1;
    chk({tag, "_pre"}, observed(), exp_vec(pre_st, rdy));
    rst_n = 1'b0;
    #1;
    chk({tag, "_zero"}, observed(), 18'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(exp_vec("IDLE", rdy));
    name_q.push_back({tag, ":IDLE"});
  endtask

  // Monitor: pop and compare at the falling edge whenever a word is pending
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [17:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, observed(), e);
      end
    end
  end

  initial begin
    int guard;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.op        = 6'd0;
    bus.mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", observed(), 18'd0);
    rst_n = 1'b1;
    exp_q.push_back(exp_vec("IDLE", 1'b0));
    name_q.push_back("rel:IDLE");

    // LW, memory always ready: 5 cycles
    cyc(LW, 1, "FETCH",  "lw");
    cyc(LW, 1, "DECODE", "lw");
    cyc(LW, 1, "MEMADR", "lw");
    cyc(LW, 1, "MEMRD",  "lw");
    cyc(LW, 1, "MEMWB",  "lw");

    // SW with three wait cycles in MEMWR
    cyc(SW, 1, "FETCH",  "sw");
    cyc(SW, 1, "DECODE", "sw");
    cyc(SW, 1, "MEMADR", "sw");
    cyc(SW, 0, "MEMWR",  "sw_w1");
    cyc(SW, 0, "MEMWR",  "sw_w2");
    cyc(SW, 0, "MEMWR",  "sw_w3");
    cyc(SW, 1, "MEMWR",  "sw_done");

    // R-type; op garbage during RTEX must be ignored
    cyc(RT,  1, "FETCH",  "rt");
    cyc(RT,  1, "DECODE", "rt");
    cyc(BAD, 1, "RTEX",   "rt");
    cyc(BAD, 1, "RTWB",   "rt");

    cyc(NORI, 1, "FETCH",  "nori");
    cyc(NORI, 1, "DECODE", "nori");
    cyc(NORI, 1, "NORIEX", "nori");
    cyc(NORI, 1, "NORIWB", "nori");

    cyc(BEQ, 1, "FETCH",  "beq");
    cyc(BEQ, 1, "DECODE", "beq");
    cyc(BEQ, 1, "BEQEX",  "beq");

    cyc(J, 1, "FETCH",  "j");
    cyc(J, 1, "DECODE", "j");
    cyc(J, 1, "JEX",    "j");

    // Illegal opcode after a fetch stall
    cyc(BAD, 0, "FETCH",      "ill_stall");
    cyc(BAD, 1, "FETCH",      "ill");
    cyc(BAD, 1, "DECODE_BAD", "ill");
    cyc(J,   1, "FETCH",      "ill_next");
    cyc(J,   1, "DECODE",     "j2");
    cyc(J,   1, "JEX",        "j2");

    // Reset while in FETCH, then restart
    do_reset(J, "FETCH", 1, "rst_fetch");
    cyc(LW, 0, "FETCH",  "rst_fetch_after");
    cyc(LW, 1, "FETCH",  "lw2");
    cyc(LW, 1, "DECODE", "lw2");
    cyc(LW, 1, "MEMADR", "lw2");
    cyc(LW, 0, "MEMRD",  "lw2_w1");

    // Reset mid memory-read wait aborts the load
    do_reset(LW, "MEMRD", 0, "rst_memrd");
    cyc(LW, 1, "FETCH",  "rst_memrd_after");
    cyc(LW, 1, "DECODE", "lw3");

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
